// File: rtl/insn_mem_responder.sv
// -----------------------------------------------------------------------------
// insn_mem_responder
//
// Memory-side responder for the fetch request/reply interface. It accepts one
// word-aligned fetch per cycle with no backpressure and returns
// {valid, addr, insn, fault} exactly LATENCY cycles later. Storage is a
// synchronous-read RAM mapped at BASE_ADDR. A loader port writes the RAM.
// flush kills every reply still in flight except a request accepted in the
// same cycle, which is the redirect target.
//
// Handshake: there is no ready. A request is taken on every cycle where
// fetch_en=1 and rst=0. The reply is presented for exactly one cycle with
// fetched_valid=1. The consumer must take it in that cycle.
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   fetch_en          request valid this cycle
//   fetch_addr        requested word address [ADDR_WIDTH-1:2]
//   flush             kill all in-flight replies
//   fetched_valid     reply valid
//   fetched_addr      word address of reply (holds its last value when idle)
//   fetched_insn      instruction word (0 when idle, FAULT_INSN on a miss)
//   fetched_fault     reply address was outside the RAM window
//   ld_we/ld_addr/ld_data  loader write port (word address)
// -----------------------------------------------------------------------------
`ifndef MSG
`define MSG(level, text) begin end
`endif

module insn_mem_responder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           LATENCY    = 1,
    parameter logic [31:0]           FAULT_INSN = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-3:0] fetch_addr,
    input  logic                  flush,
    output logic                  fetched_valid,
    output logic [ADDR_WIDTH-3:0] fetched_addr,
    output logic [31:0]           fetched_insn,
    output logic                  fetched_fault,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-3:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int unsigned WA        = ADDR_WIDTH - 2;
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WA-1:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH-1:2];

    // Elaboration-time parameter checks.
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "insn_mem_responder: LATENCY must be 1..4");
    end
    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
        $fatal(1, "insn_mem_responder: MEM_WORDS must be a power of 2, >= 2");
    end

    // ---------------------------------------------------------------------
    // Window decode. Offsets use modular WA-bit arithmetic, so an address
    // below BASE wraps to a huge offset and misses; no wrap special case.
    // ---------------------------------------------------------------------
    logic [WA-1:0]    fetch_off;
    logic [WA-1:0]    ld_off;
    logic             fetch_hit;
    logic             ld_hit;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ld_idx;
    logic             accept;
    logic             rd_en;
    logic             wr_en;

    assign fetch_off = fetch_addr - BASE_WORD;
    assign ld_off    = ld_addr - BASE_WORD;
    assign fetch_hit = (fetch_off >> IDX_W) == '0;
    assign ld_hit    = (ld_off >> IDX_W) == '0;
    assign fetch_idx = fetch_off[IDX_W-1:0];
    assign ld_idx    = ld_off[IDX_W-1:0];

    assign accept = fetch_en && !rst;
    assign rd_en  = accept && fetch_hit;   // misses never touch the RAM
    assign wr_en  = ld_we && !rst && ld_hit;

    // ---------------------------------------------------------------------
    // RAM: synchronous read, read-before-write on a same-index collision
    // (the read samples the array before the non-blocking write lands).
    // ---------------------------------------------------------------------
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_idx] <= ld_data;
        end
        if (rd_en) begin
            rd_data <= mem[fetch_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: the RAM read stage. Its contents are always replaced by the
    // request of the current cycle, so flush never needs to touch it.
    // ---------------------------------------------------------------------
    logic          s1_valid;
    logic [WA-1:0] s1_addr;
    logic          s1_fault;
    logic [31:0]   s1_insn;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_fault <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= fetch_addr;
                s1_fault <= !fetch_hit;
            end
        end
    end

    assign s1_insn = s1_fault ? FAULT_INSN : rd_data;

    // ---------------------------------------------------------------------
    // Stages 2..LATENCY and output selection.
    // ---------------------------------------------------------------------
    if (LATENCY == 1) begin : g_lat1
        // Stage 1 is the output register. flush has no effect here: a
        // request accepted with flush is kept, and anything older has
        // already been presented.
        logic unused_flush;
        assign unused_flush = flush;

        assign fetched_valid = s1_valid;
        assign fetched_addr  = s1_addr;
        assign fetched_insn  = s1_valid ? s1_insn : 32'h0;
        assign fetched_fault = s1_valid && s1_fault;
    end else begin : g_latn
        logic          p_valid [2:LATENCY];
        logic [WA-1:0] p_addr  [2:LATENCY];
        logic [31:0]   p_insn  [2:LATENCY];
        logic          p_fault [2:LATENCY];

        // Uniform view of stages 1..LATENCY so each stage copies the one
        // below it without special-casing stage 1.
        logic          cur_valid [1:LATENCY];
        logic [WA-1:0] cur_addr  [1:LATENCY];
        logic [31:0]   cur_insn  [1:LATENCY];
        logic          cur_fault [1:LATENCY];

        always_comb begin
            cur_valid[1] = s1_valid;
            cur_addr[1]  = s1_addr;
            cur_insn[1]  = s1_insn;
            cur_fault[1] = s1_fault;
            for (int k = 2; k <= int'(LATENCY); k++) begin
                cur_valid[k] = p_valid[k];
                cur_addr[k]  = p_addr[k];
                cur_insn[k]  = p_insn[k];
                cur_fault[k] = p_fault[k];
            end
        end

        // Payload only moves with a live entry, so the output register's
        // address holds the last reply while idle.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 2; k <= int'(LATENCY); k++) begin
                    p_valid[k] <= 1'b0;
                    p_addr[k]  <= '0;
                    p_insn[k]  <= '0;
                    p_fault[k] <= 1'b0;
                end
            end else begin
                for (int k = 2; k <= int'(LATENCY); k++) begin
                    p_valid[k] <= cur_valid[k-1] && !flush;
                    if (cur_valid[k-1] && !flush) begin
                        p_addr[k]  <= cur_addr[k-1];
                        p_insn[k]  <= cur_insn[k-1];
                        p_fault[k] <= cur_fault[k-1];
                    end
                end
            end
        end

        assign fetched_valid = cur_valid[LATENCY];
        assign fetched_addr  = cur_addr[LATENCY];
        assign fetched_insn  = cur_valid[LATENCY] ? cur_insn[LATENCY] : 32'h0;
        assign fetched_fault = cur_valid[LATENCY] && cur_fault[LATENCY];
    end

    // Reply trace; compiles to nothing unless MSG is provided externally.
    always_ff @(posedge clk) begin
        if (fetched_valid) begin
            `MSG(5, ("fetch reply addr=%h insn=%h fault=%b",
                     {fetched_addr, 2'b00}, fetched_insn, fetched_fault))
        end
    end

endmodule

// File: tb/tb_insn_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for insn_mem_responder. Three instances share one stimulus stream:
//   inst 0: LATENCY=1, BASE=0,      1024 words, FAULT_INSN=0
//   inst 1: LATENCY=3, BASE=0x1000, 1024 words, FAULT_INSN=DEADBEEF
//   inst 2: LATENCY=2, BASE=0,      16 words,   FAULT_INSN=00000013
// A reference model keeps per-instance RAM images and a queue of pending
// replies tagged with the clock edge on which each must appear.
// -----------------------------------------------------------------------------
module tb_insn_mem_responder;

  localparam int WA = 30;

  typedef struct {
    logic          rst;
    logic          fetch_en;
    logic [WA-1:0] fetch_addr;
    logic          flush;
    logic          ld_we;
    logic [WA-1:0] ld_addr;
    logic [31:0]   ld_data;
  } in_t;

  typedef struct {
    in_t           in;
    logic          v;
    logic [WA-1:0] a;
    logic [31:0]   i;
    logic          f;
  } vec_t;

  typedef struct {
    int            inst;
    int            due;
    logic [WA-1:0] addr;
    logic [31:0]   insn;
    logic          fault;
  } pend_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, fetch_en, flush, ld_we;
  logic [WA-1:0] fetch_addr, ld_addr;
  logic [31:0]   ld_data;

  logic          v0, v1, v2, f0, f1, f2;
  logic [WA-1:0] a0, a1, a2;
  logic [31:0]   i0, i1, i2;

  always #5 clk = ~clk;

  insn_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0),
                       .LATENCY(1), .FAULT_INSN(32'h0)) u_l1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .flush(flush),
    .fetched_valid(v0), .fetched_addr(a0), .fetched_insn(i0), .fetched_fault(f0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  insn_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h1000),
                       .LATENCY(3), .FAULT_INSN(32'hDEAD_BEEF)) u_l3 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .flush(flush),
    .fetched_valid(v1), .fetched_addr(a1), .fetched_insn(i1), .fetched_fault(f1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  insn_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(16), .BASE_ADDR(32'h0),
                       .LATENCY(2), .FAULT_INSN(32'h0000_0013)) u_l2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .flush(flush),
    .fetched_valid(v2), .fetched_addr(a2), .fetched_insn(i2), .fetched_fault(f2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  // ---------------- reference model ----------------
  int            lat_c   [3] = '{1, 3, 2};
  int            words_c [3] = '{1024, 1024, 16};
  logic [WA-1:0] base_c  [3] = '{30'h0, 30'h400, 30'h0};
  logic [31:0]   finsn_c [3] = '{32'h0, 32'hDEAD_BEEF, 32'h0000_0013};

  logic [31:0]   mem_m [3][1024];
  pend_t         exp_q [$];
  logic          exp_v [3];
  logic [WA-1:0] exp_a [3];
  logic [31:0]   exp_i [3];
  logic          exp_f [3];
  logic [WA-1:0] last_addr [3];
  int            edge_n;

  int n_cmp;
  int n_fail;

  function automatic void drop_inst(int i);
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].inst == i) exp_q.delete(j);
    end
  endfunction

  // Applies the inputs sampled at this edge to the model and derives the
  // outputs each instance must show until the next edge.
  task automatic model_edge();
    logic [WA-1:0] off;
    pend_t         p;
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        drop_inst(i);
        last_addr[i] = '0;
        exp_v[i] = 1'b0; exp_a[i] = '0; exp_i[i] = '0; exp_f[i] = 1'b0;
      end else begin
        if (flush) drop_inst(i);
        if (fetch_en) begin
          off     = fetch_addr - base_c[i];
          p.inst  = i;
          p.due   = edge_n + lat_c[i] - 1;
          p.addr  = fetch_addr;
          p.fault = !(off < WA'(words_c[i]));
          p.insn  = p.fault ? finsn_c[i] : mem_m[i][off[9:0]];
          exp_q.push_back(p);
        end
        if (ld_we) begin
          off = ld_addr - base_c[i];
          if (off < WA'(words_c[i])) mem_m[i][off[9:0]] = ld_data;
        end
        exp_v[i] = 1'b0; exp_i[i] = '0; exp_f[i] = 1'b0; exp_a[i] = last_addr[i];
        for (int j = 0; j < exp_q.size(); j++) begin
          if (exp_q[j].inst == i) begin
            if (exp_q[j].due == edge_n) begin
              exp_v[i] = 1'b1;
              exp_a[i] = exp_q[j].addr;
              exp_i[i] = exp_q[j].insn;
              exp_f[i] = exp_q[j].fault;
              last_addr[i] = exp_q[j].addr;
              exp_q.delete(j);
            end
            break;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic get_act(input int i, output logic v, output logic [WA-1:0] a,
                         output logic [31:0] ins, output logic f);
    case (i)
      0:       begin v = v0; a = a0; ins = i0; f = f0; end
      1:       begin v = v1; a = a1; ins = i1; f = f1; end
      default: begin v = v2; a = a2; ins = i2; f = f2; end
    endcase
  endtask

  task automatic check_one(input int i, input string tag, input logic ev,
                           input logic [WA-1:0] ea, input logic [31:0] ei,
                           input logic ef, input bit chk_addr);
    logic v, f;
    logic [WA-1:0] a;
    logic [31:0] ins;
    get_act(i, v, a, ins, f);
    n_cmp++;
    if (v !== ev || ins !== ei || f !== ef || (chk_addr && a !== ea)) begin
      n_fail++;
      $display("FAIL %s inst%0d @edge %0d: got v=%b addr=%h insn=%h fault=%b, want v=%b addr=%h insn=%h fault=%b",
               tag, i, edge_n, v, a, ins, f, ev, ea, ei, ef);
    end
  endtask

  // ---------------- driver ----------------
  function automatic in_t mk(logic r, logic fe, logic [WA-1:0] fa, logic fl,
                             logic we, logic [WA-1:0] la, logic [31:0] ld);
    in_t x;
    x.rst = r; x.fetch_en = fe; x.fetch_addr = fa; x.flush = fl;
    x.ld_we = we; x.ld_addr = la; x.ld_data = ld;
    return x;
  endfunction

  function automatic vec_t mkv(in_t x, logic v, logic [WA-1:0] a, logic [31:0] i, logic f);
    vec_t r;
    r.in = x; r.v = v; r.a = a; r.i = i; r.f = f;
    return r;
  endfunction

  function automatic logic [WA-1:0] rand_word();
    int unsigned sel = $urandom_range(0, 9);
    if (sel == 0) return WA'($urandom);
    if (sel == 1) return 30'h3FFF_FFFF - WA'($urandom_range(0, 3));
    return WA'($urandom_range(0, 32'h83F));
  endfunction

  // One clock: drive while clk is low, update the model at the edge,
  // compare every instance on the falling edge.
  task automatic drive(input in_t x);
    rst = x.rst; fetch_en = x.fetch_en; fetch_addr = x.fetch_addr; flush = x.flush;
    ld_we = x.ld_we; ld_addr = x.ld_addr; ld_data = x.ld_data;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_one(i, "model", exp_v[i], exp_a[i], exp_i[i], exp_f[i], 1'b1);
  endtask

  task automatic fetch(input logic [WA-1:0] a, input logic fl);
    drive(mk(1'b0, 1'b1, a, fl, 1'b0, '0, '0));
  endtask

  task automatic load(input logic [WA-1:0] a, input logic [31:0] d);
    drive(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, a, d));
  endtask

  task automatic idle();
    drive(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs [20];
    in_t  x;

    n_cmp = 0; n_fail = 0; edge_n = 0;
    for (int i = 0; i < 3; i++) last_addr[i] = '0;

    // Directed table for inst 0 (LATENCY=1, BASE=0): back-to-back fetch,
    // read/write collision, out-of-window fetch and dropped write, flush.
    vecs[0]  = mkv(mk(0, 0, 30'h0,   0, 1, 30'h0,   32'h11),   0, 30'h0,   32'h0,    0);
    vecs[1]  = mkv(mk(0, 0, 30'h0,   0, 1, 30'h1,   32'h22),   0, 30'h0,   32'h0,    0);
    vecs[2]  = mkv(mk(0, 0, 30'h0,   0, 1, 30'h2,   32'h33),   0, 30'h0,   32'h0,    0);
    vecs[3]  = mkv(mk(0, 0, 30'h0,   0, 1, 30'h3,   32'h44),   0, 30'h0,   32'h0,    0);
    vecs[4]  = mkv(mk(0, 1, 30'h0,   0, 0, 30'h0,   32'h0),    1, 30'h0,   32'h11,   0);
    vecs[5]  = mkv(mk(0, 1, 30'h1,   0, 0, 30'h0,   32'h0),    1, 30'h1,   32'h22,   0);
    vecs[6]  = mkv(mk(0, 1, 30'h2,   0, 0, 30'h0,   32'h0),    1, 30'h2,   32'h33,   0);
    vecs[7]  = mkv(mk(0, 1, 30'h3,   0, 0, 30'h0,   32'h0),    1, 30'h3,   32'h44,   0);
    vecs[8]  = mkv(mk(0, 0, 30'h0,   0, 0, 30'h0,   32'h0),    0, 30'h3,   32'h0,    0);
    vecs[9]  = mkv(mk(0, 0, 30'h0,   0, 1, 30'h5,   32'hAAAA), 0, 30'h3,   32'h0,    0);
    vecs[10] = mkv(mk(0, 1, 30'h5,   0, 1, 30'h5,   32'hBBBB), 1, 30'h5,   32'hAAAA, 0);
    vecs[11] = mkv(mk(0, 1, 30'h5,   0, 0, 30'h0,   32'h0),    1, 30'h5,   32'hBBBB, 0);
    vecs[12] = mkv(mk(0, 0, 30'h0,   0, 0, 30'h0,   32'h0),    0, 30'h5,   32'h0,    0);
    vecs[13] = mkv(mk(0, 1, 30'h400, 0, 0, 30'h0,   32'h0),    1, 30'h400, 32'h0,    1);
    vecs[14] = mkv(mk(0, 0, 30'h0,   0, 1, 30'h400, 32'h55),   0, 30'h400, 32'h0,    0);
    vecs[15] = mkv(mk(0, 1, 30'h400, 0, 0, 30'h0,   32'h0),    1, 30'h400, 32'h0,    1);
    vecs[16] = mkv(mk(0, 1, 30'h0,   0, 0, 30'h0,   32'h0),    1, 30'h0,   32'h11,   0);
    vecs[17] = mkv(mk(0, 0, 30'h0,   1, 0, 30'h0,   32'h0),    0, 30'h0,   32'h0,    0);
    vecs[18] = mkv(mk(0, 1, 30'h1,   1, 0, 30'h0,   32'h0),    1, 30'h1,   32'h22,   0);
    vecs[19] = mkv(mk(0, 0, 30'h0,   0, 0, 30'h0,   32'h0),    0, 30'h1,   32'h0,    0);

    // Reset: all outputs zero.
    drive(mk(1'b1, 1'b1, 30'h7, 1'b1, 1'b0, '0, '0));
    drive(mk(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0));
    for (int i = 0; i < 3; i++) check_one(i, "reset", 1'b0, '0, '0, 1'b0, 1'b1);

    // Fill every RAM window with known data.
    for (int w = 0; w < 32'h800; w++) load(WA'(w), $urandom);

    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].in);
      check_one(0, $sformatf("table%0d", k), vecs[k].v, vecs[k].a, vecs[k].i, vecs[k].f, 1'b1);
    end

    // LATENCY=3 gap: requests two cycles apart, idle cycle between replies.
    load(30'h401, 32'h1111_0001);
    load(30'h402, 32'h2222_0002);
    idle(); idle(); idle();
    fetch(30'h401, 1'b0);  check_one(1, "gap_e0", 1'b0, '0, 32'h0, 1'b0, 1'b0);
    idle();                check_one(1, "gap_e1", 1'b0, '0, 32'h0, 1'b0, 1'b0);
    fetch(30'h402, 1'b0);  check_one(1, "gap_a",  1'b1, 30'h401, 32'h1111_0001, 1'b0, 1'b1);
    idle();                check_one(1, "gap_hole", 1'b0, 30'h401, 32'h0, 1'b0, 1'b1);
    idle();                check_one(1, "gap_b",  1'b1, 30'h402, 32'h2222_0002, 1'b0, 1'b1);

    // Window edges on inst 1 (BASE=0x1000): 0x0FFC and 0x2000 miss, 0x1FFC hits.
    load(30'h7FF, 32'hCAFE_0123);
    fetch(30'h3FF, 1'b0);
    fetch(30'h800, 1'b0);
    fetch(30'h7FF, 1'b0);  check_one(1, "win_below", 1'b1, 30'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle();                check_one(1, "win_above", 1'b1, 30'h800, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle();                check_one(1, "win_last",  1'b1, 30'h7FF, 32'hCAFE_0123, 1'b0, 1'b1);

    // Flush on inst 1: A and B killed, C (with flush) and D delivered.
    load(30'h412, 32'h0C0C_0C0C);
    load(30'h413, 32'h0D0D_0D0D);
    idle(); idle();
    fetch(30'h410, 1'b0);
    fetch(30'h411, 1'b0);
    fetch(30'h412, 1'b1);  check_one(1, "flush_a", 1'b0, '0, 32'h0, 1'b0, 1'b0);
    fetch(30'h413, 1'b0);  check_one(1, "flush_b", 1'b0, '0, 32'h0, 1'b0, 1'b0);
    idle();                check_one(1, "flush_c", 1'b1, 30'h412, 32'h0C0C_0C0C, 1'b0, 1'b1);
    idle();                check_one(1, "flush_d", 1'b1, 30'h413, 32'h0D0D_0D0D, 1'b0, 1'b1);

    // Reset mid-flight on inst 2 (LATENCY=2).
    load(30'h4, 32'h4444_0004);
    idle(); idle();
    fetch(30'h3, 1'b0);    check_one(2, "rstf_e0", 1'b0, '0, 32'h0, 1'b0, 1'b0);
    drive(mk(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0));
                           check_one(2, "rstf_e1", 1'b0, '0, 32'h0, 1'b0, 1'b1);
    idle();                check_one(2, "rstf_e2", 1'b0, '0, 32'h0, 1'b0, 1'b1);
    idle();                check_one(2, "rstf_e3", 1'b0, '0, 32'h0, 1'b0, 1'b1);
    fetch(30'h4, 1'b0);    check_one(2, "rstf_e4", 1'b0, '0, 32'h0, 1'b0, 1'b1);
    idle();                check_one(2, "rstf_new", 1'b1, 30'h4, 32'h4444_0004, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      x.rst        = ($urandom_range(0, 99) < 2);
      x.fetch_en   = ($urandom_range(0, 9) < 7);
      x.fetch_addr = rand_word();
      x.flush      = ($urandom_range(0, 99) < 5);
      x.ld_we      = ($urandom_range(0, 4) == 0);
      x.ld_addr    = rand_word();
      x.ld_data    = $urandom;
      drive(x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
